sbox_sequencer: RTL and testbench



---
 rtl/sbox_sequencer.sv | 132 +++++++++++++
 tb/tb_sbox_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sbox_sequencer.sv
// Time-multiplexed DES S-box sequencer: walks a 48-bit word through S1..S8 and assembles the 32-bit result.
// Define SBOX_SEQ_DUAL_EN to perform two lookups per RUN cycle (4 RUN cycles instead of 8).
module sbox_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [48:1] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:1] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Each entry is one S-box, row-major (row*16+col), first nibble at the MSB.
   localparam logic [255:0] SBOX_TAB [0:7] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   // Row is the chunk's outer bits, column its inner four bits.
   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
      logic [255:0] tab;
      tab = SBOX_TAB[box] << {chunk[5], chunk[0], chunk[4:1], 2'b00};
      return tab[255:252];
   endfunction

   state_t      state_reg;
   logic [2:0]  cnt_reg;
   logic [48:1] operand_reg;

   logic [5:0]  chunk  [0:7];
   logic [5:0]  box_in [0:7];
   logic [3:0]  lut    [0:7];
   logic [2:0]  sel_a;
   logic [5:0]  chunk_a;
   logic [3:0]  nib_a;
   logic        last_step;

`ifdef SBOX_SEQ_DUAL_EN
   logic [2:0]  sel_b;
   logic [5:0]  chunk_b;
   logic [3:0]  nib_b;

   assign sel_a     = {cnt_reg[1:0], 1'b0};
   assign sel_b     = {cnt_reg[1:0], 1'b1};
   assign chunk_b   = chunk[sel_b];
   assign nib_b     = lut[sel_b];
   assign last_step = (cnt_reg == 3'd3);
`else
   assign sel_a     = cnt_reg;
   assign last_step = (cnt_reg == 3'd7);
`endif

   assign chunk_a = chunk[sel_a];
   assign nib_a   = lut[sel_a];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_box
         assign chunk[gi] = operand_reg[48-6*gi -: 6];
`ifdef SBOX_SEQ_DUAL_EN
         // Even boxes take the first chunk of the pair, odd boxes the second.
         assign box_in[gi] = (gi % 2 == 1) ? chunk_b : chunk_a;
`else
         assign box_in[gi] = chunk_a;
`endif
         assign lut[gi] = sbox_lookup(3'(gi), box_in[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         operand_reg <= '0;
         out_data    <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready) begin
                  operand_reg <= in_data;
                  out_data    <= '0;
                  cnt_reg     <= '0;
                  state_reg   <= RUN;
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            RUN: begin
               for (int i = 0; i < 8; i++) begin
                  if (sel_a == 3'(i)) out_data[32-4*i -: 4] <= nib_a;
`ifdef SBOX_SEQ_DUAL_EN
                  if (sel_b == 3'(i)) out_data[32-4*i -: 4] <= nib_b;
`endif
               end
               cnt_reg <= cnt_reg + 3'd1;
               if (last_step) begin
                  state_reg <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // in_ready rises only after this edge, so no accept can share the handshake cycle.
               if (out_valid && out_ready) begin
                  state_reg <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_sequencer.sv
// Self-checking bench for sbox_sequencer: vector table, hand-written corner cases and a randomized run.
module tb_sbox_sequencer;

`ifdef SBOX_SEQ_DUAL_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [48:1] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [32:1] out_data;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   sbox_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Standard DES S-boxes, SB[box][row*16 + col].
   int SB [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
   };

   function automatic logic [32:1] ref_model(input logic [48:1] w);
      logic [32:1] r;
      int c, row, col;
      r = '0;
      for (int k = 1; k <= 8; k++) begin
         c   = int'((w >> (48 - 6*k)) & 48'h3F);
         row = ((c >> 5) & 1) * 2 + (c & 1);
         col = (c >> 1) & 15;
         r   = r | (32'(SB[k-1][row*16 + col]) << (32 - 4*k));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      check({name, "_out_valid"}, 64'(out_valid), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_out_data"}, 64'(out_data), 64'd0);
   endtask

   // One full transaction; noisy=1 scrambles in_data/in_valid/out_ready while the word is in flight.
   task automatic xfer(input string name, input logic [48:1] w, input logic [32:1] exp,
                       input int stall, input bit noisy);
      int lat;
      bit ready_leak;
      bit unstable;
      logic [32:1] first;
      @(negedge clk);
      check({name, "_ready_before"}, 64'(in_ready), 64'd1);
      in_data  = w;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_busy_run"}, 64'(busy), 64'd1);
      lat = 0;
      ready_leak = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) ready_leak = 1'b1;
         if (noisy) begin
            in_data   = {16'($urandom), $urandom};
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      in_valid  = noisy;
      out_ready = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'(LAT));
      check({name, "_no_reaccept"}, 64'(ready_leak), 64'd0);
      check({name, "_data"}, 64'(out_data), 64'(exp));
      first = out_data;
      unstable = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || out_data !== first || in_ready) unstable = 1'b1;
      end
      if (stall > 0) check({name, "_stall_stable"}, 64'(unstable), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_post_ready"}, 64'(in_ready), 64'd1);
      check({name, "_post_valid"}, 64'(out_valid), 64'd0);
      check({name, "_post_busy"}, 64'(busy), 64'd0);
      check({name, "_post_hold"}, 64'(out_data), 64'(first));
      in_valid = 1'b0;
      $display("xfer %s in=%h out=%h exp=%h lat=%0d stall=%0d", name, w, first, exp, lat, stall);
   endtask

   typedef struct {
      logic [48:1] din;
      logic [32:1] dout;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [48:1] w;

      vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
      vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
      vecs[2] = '{48'h0123456789AB, ref_model(48'h0123456789AB)};
      vecs[3] = '{48'hA5A5A5F0F0F0, ref_model(48'hA5A5A5F0F0F0)};

      #3 rst_n = 1'b0;
      #1 check_idle_outputs("reset_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_release");

      for (int i = 0; i < 4; i++)
         xfer($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout, 0, 1'b0);

      // Long back-pressure in DONE.
      xfer("backpressure", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 20, 1'b0);

      // Input churn and in_valid pulses while running, in_valid held through the handshake.
      xfer("churn", 48'h13579BDF2468, ref_model(48'h13579BDF2468), 2, 1'b1);

      // Reset after three RUN cycles discards the partial result.
      @(negedge clk);
      in_data  = '0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("partial_before_reset", 64'(out_data), 64'(32'hEFA00000));
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("reset_midrun");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_midrun_release");
      xfer("after_reset", 48'h000000000000, 32'hEFA72C4D, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         w = {16'($urandom), $urandom};
         xfer($sformatf("rnd%0d", i), w, ref_model(w), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
